sipo_capture: RTL and testbench
===============================

Name: sipo_capture

Overview:
- Serial-in/parallel-out capture stage directly downstream of the d_ff bit register.
- Consumes the registered serial bit (the d_ff q_next output) one bit per qualified clock.
- Assembles WIDTH-bit MSB-first frames and presents each frame on a valid/ready parallel interface.
- Flags frames lost because the consumer stalled.

Parameters:
- WIDTH, 8: data bits per frame; legal range 2..32.
- CNT_W, $clog2(WIDTH+1): bit-counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock, shared with the upstream d_ff.
- rst  input  1  synchronous, active-high reset.
- d_in  input  1  serial bit from the upstream d_ff q_next.
- shift_en  input  1  qualifies d_in as a valid bit this cycle.
- start  input  1  frame start; the bit sampled with start=1 and shift_en=1 is the frame MSB.
- data_out  output  WIDTH  assembled frame, MSB first-received.
- valid_out  output  1  data_out holds a complete frame.
- ready_in  input  1  consumer accepts data_out when valid_out=1.
- busy  output  1  frame assembly in progress (state SHIFT).
- overrun  output  1  sticky; a bit arrived while a frame was held unaccepted.
- parity_err  output  1  see Optional Feature.

Behaviour:
- Clocking and reset:
  - Single clock domain, clk only.
  - rst is synchronous and active-high, sampled on the rising edge of clk.
  - rst dominates all other inputs.
- Reset values: state=IDLE, data_out=0, valid_out=0, busy=0, overrun=0, parity_err=0, bit counter=0.
- FSM states:
  - IDLE: waiting for start.
  - SHIFT: collecting bits.
  - HOLD: frame presented, awaiting acceptance.
- IDLE:
  - start=1 and shift_en=1: shift register = {.., d_in}, counter=1, go to SHIFT.
  - start=1 and shift_en=0: ignored; remain in IDLE.
- SHIFT:
  - Each cycle with shift_en=1: shift left, insert d_in at LSB, counter+1.
  - Cycles with shift_en=0: hold all state.
  - start=1 with shift_en=1 mid-frame: frame restarts. Partial bits are discarded, counter=1, d_in becomes the new MSB.
  - When the WIDTH-th bit is captured: data_out is loaded on that same edge, valid_out=1 on the next cycle, go to HOLD.
  - Latency: last bit on edge N -> valid_out high after edge N.
- HOLD:
  - data_out and valid_out stay stable until valid_out & ready_in.
  - On transfer with start=1 and shift_en=1 in the same cycle: valid_out=0 and a new frame begins (SHIFT, counter=1). Back-to-back frames therefore lose no bits.
  - On transfer without start: valid_out=0, go to IDLE.
  - shift_en=1 with no transfer: the bit is dropped and overrun is set to 1. overrun clears only on rst.
- ready_in while valid_out=0: ignored.
- busy = (state == SHIFT).
- Counter never exceeds WIDTH; any other state encoding recovers to IDLE.
- rst mid-frame or in HOLD: every output returns to its reset value on that edge, and the partial frame is discarded.

Optional Feature:
- Macro: SIPO_PARITY_EN.
- Defined:
  - Each frame is WIDTH data bits plus one trailing even-parity bit. The counter runs to WIDTH+1.
  - The parity bit is not placed in data_out.
  - parity_err is set with valid_out when the XOR of the data bits and the parity bit is 1.
  - parity_err clears when the frame is accepted.
- Undefined: frames are WIDTH bits only, and parity_err is tied to 0.

Decomposition:
- Package sipo_pkg holds:
  - the state enum (IDLE=2'd0, SHIFT=2'd1, HOLD=2'd2);
  - the default WIDTH constant;
  - the parity-calculation function.
- One sub-module, sipo_shift_reg: WIDTH-bit shift register with load-enable and clear.
- FSM, counter, handshake and flags live in the top level.

Test Plan:
- Reset: rst=1 for 2 cycles with random d_in/shift_en -> all outputs 0 and busy=0.
- Single frame: start+shift_en with bits 1,0,1,1,0,0,1,0 and ready_in=1 -> data_out=8'hB2, valid_out high exactly 1 cycle, overrun=0.
- Gapped shifting: same bits with shift_en=0 inserted between each bit -> data_out=8'hB2, and valid_out only after the 8th qualified bit.
- Stall and overrun:
  - Frame 8'h5A with ready_in=0 for 4 cycles while shift_en=1.
  - Required: data_out stays 8'h5A, overrun=1.
  - Then ready_in=1: valid_out drops and overrun stays 1.
- Restart and back-to-back:
  - start reasserted after 3 bits, then bits for 8'hFF -> data_out=8'hFF.
  - Accept with start+shift_en in the same cycle, then bits for 8'h01 -> the second frame is 8'h01 with no gap cycle.
- Reset mid-frame: rst after 5 bits -> outputs 0; the next full frame 8'hC3 captures correctly. With SIPO_PARITY_EN, parity bit 1 on 8'hC3 -> parity_err=1.

Source files
------------

// File: rtl/sipo_pkg.sv
// Shared types, default frame width and parity helper
// for the sipo_capture serial-to-parallel stage.
package sipo_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  function automatic logic parity_of(
    input logic [31:0] v
  );
    return ^v;
  endfunction

endpackage

// File: rtl/sipo_shift_reg.sv
// WIDTH-bit left shift register, LSB insert.
// Ports: clk, clr (sync clear), en (shift), d_in, q.
module sipo_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             d_in,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= {q[WIDTH-2:0], d_in};
    end
  end

endmodule

// File: rtl/sipo_capture.sv
// SIPO capture: MSB-first WIDTH-bit frames on valid/ready.
// Ports: clk, rst (sync, high), d_in, shift_en, start,
//   data_out, valid_out, ready_in, busy, overrun,
//   parity_err. Macro SIPO_PARITY_EN adds a trailing
//   even-parity bit per frame and drives parity_err.
module sipo_capture
  import sipo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             d_in,
  input  logic             shift_en,
  input  logic             start,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  input  logic             ready_in,
  output logic             busy,
  output logic             overrun,
  output logic             parity_err
);

`ifdef SIPO_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif
  localparam int CNT_W = $clog2(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [WIDTH-1:0] sr_q, data_n;
  logic             valid_n, ovr_n, sr_en;
  logic             xfer, fire, last;

`ifdef SIPO_PARITY_EN
  logic perr_q, perr_n;
`else
  logic unused_msb;
  assign unused_msb = sr_q[WIDTH-1];
`endif

  assign xfer = valid_out & ready_in;
  assign fire = start & shift_en;
  assign last = (cnt == LAST);
  assign busy = (state == SHIFT);

  sipo_shift_reg #(.WIDTH(WIDTH)) u_sr (
    .clk  (clk),
    .clr  (rst),
    .en   (sr_en),
    .d_in (d_in),
    .q    (sr_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      data_out  <= data_n;
      valid_out <= valid_n;
      overrun   <= ovr_n;
    end
  end

`ifdef SIPO_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perr_q <= 1'b0;
    end else begin
      perr_q <= perr_n;
    end
  end
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    data_n  = data_out;
    valid_n = valid_out;
    ovr_n   = overrun;
    sr_en   = 1'b0;
`ifdef SIPO_PARITY_EN
    perr_n  = perr_q;
`endif
    case (state)
      IDLE: begin
        if (fire) begin
          sr_en   = 1'b1;
          cnt_n   = ONE;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (shift_en) begin
          sr_en = 1'b1;
          if (start) begin
            cnt_n = ONE;
          end else if (last) begin
            cnt_n   = '0;
            state_n = HOLD;
            valid_n = 1'b1;
`ifdef SIPO_PARITY_EN
            // register already holds all data bits;
            // d_in is the parity bit
            data_n = sr_q;
            perr_n = parity_of(32'(sr_q)) ^ d_in;
`else
            data_n = {sr_q[WIDTH-2:0], d_in};
`endif
          end else begin
            cnt_n = cnt + ONE;
          end
        end
      end
      HOLD: begin
        if (xfer) begin
          valid_n = 1'b0;
`ifdef SIPO_PARITY_EN
          perr_n  = 1'b0;
`endif
          if (fire) begin
            sr_en   = 1'b1;
            cnt_n   = ONE;
            state_n = SHIFT;
          end else begin
            state_n = IDLE;
          end
        end else if (shift_en) begin
          ovr_n = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        valid_n = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_sipo_capture.sv
// Randomized and directed bench for sipo_capture,
// checked against a queue-based frame model.
module tb_sipo_capture;

  localparam int W = 8;
`ifdef SIPO_PARITY_EN
  localparam int FL  = W + 1;
  localparam bit PAR = 1'b1;
`else
  localparam int FL  = W;
  localparam bit PAR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         d_in = 1'b0;
  logic         shift_en = 1'b0;
  logic         start = 1'b0;
  logic         ready_in = 1'b0;
  logic [W-1:0] data_out;
  logic         valid_out;
  logic         busy;
  logic         overrun;
  logic         parity_err;

  sipo_capture #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .d_in       (d_in),
    .shift_en   (shift_en),
    .start      (start),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .ready_in   (ready_in),
    .busy       (busy),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  bit           m_act;
  bit           m_bits[$];
  logic [W-1:0] m_data;
  bit           m_valid;
  bit           m_ovr;
  bit           m_perr;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  tag, got, exp);
  endtask

  task automatic model_clk(
    input bit r, s, se, d, rd
  );
    logic [W-1:0] v;
    bit           x;
    v = '0;
    x = 1'b0;
    if (r) begin
      m_act   = 1'b0;
      m_bits.delete();
      m_data  = '0;
      m_valid = 1'b0;
      m_ovr   = 1'b0;
      m_perr  = 1'b0;
    end else if (m_valid) begin
      if (rd) begin
        m_valid = 1'b0;
        m_perr  = 1'b0;
        m_bits.delete();
        m_act   = s && se;
        if (m_act) m_bits.push_back(d);
      end else if (se) begin
        m_ovr = 1'b1;
      end
    end else if (se && (s || m_act)) begin
      if (s) m_bits.delete();
      m_bits.push_back(d);
      m_act = 1'b1;
      if (m_bits.size() == FL) begin
        for (int i = 0; i < W; i++)
          v = {v[W-2:0], m_bits[i]};
        foreach (m_bits[i]) x = x ^ m_bits[i];
        m_data  = v;
        m_perr  = PAR & x;
        m_valid = 1'b1;
        m_act   = 1'b0;
        m_bits.delete();
      end
    end
  endtask

  task automatic step(
    input bit r, s, se, d, rd
  );
    rst      = r;
    start    = s;
    shift_en = se;
    d_in     = d;
    ready_in = rd;
    @(posedge clk);
    model_clk(r, s, se, d, rd);
    #1;
    check("valid", valid_out, m_valid);
    check("data", data_out, m_data);
    check("busy", busy, m_act);
    check("overrun", overrun, m_ovr);
    check("parity_err", parity_err, m_perr);
  endtask

  task automatic push_frame(
    input logic [W-1:0] v,
    input bit gaps,
    input bit rdy_first,
    input bit bad_par,
    input bit rdy
  );
    for (int i = 0; i < W; i++) begin
      step(1'b0, i == 0, 1'b1, v[W-1-i],
           (i == 0) ? rdy_first : rdy);
      if (gaps && (i < W - 1))
        step(1'b0, 1'b0, 1'b0, 1'($urandom), rdy);
    end
    if (PAR) begin
      if (gaps) step(1'b0, 1'b0, 1'b0, 1'($urandom), rdy);
      step(1'b0, 1'b0, 1'b1, (^v) ^ bad_par, rdy);
    end
  endtask

  initial begin
    // reset with random bus activity
    repeat (2)
      step(1'b1, 1'($urandom), 1'($urandom),
           1'($urandom), 1'($urandom));
    check("rst_data", data_out, 0);
    check("rst_valid", valid_out, 0);
    check("rst_busy", busy, 0);
    check("rst_ovr", overrun, 0);
    check("rst_perr", parity_err, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // single frame
    push_frame(8'hB2, 1'b0, 1'b0, 1'b0, 1'b1);
    check("t2_data", data_out, 8'hB2);
    check("t2_valid", valid_out, 1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("t2_valid_1cyc", valid_out, 0);
    check("t2_ovr", overrun, 0);

    // gapped shifting
    push_frame(8'hB2, 1'b1, 1'b0, 1'b0, 1'b1);
    check("t3_data", data_out, 8'hB2);
    check("t3_valid", valid_out, 1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // stall and overrun
    push_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (4)
      step(1'b0, 1'b0, 1'b1, 1'($urandom), 1'b0);
    check("t4_data", data_out, 8'h5A);
    check("t4_ovr", overrun, 1);
    check("t4_valid", valid_out, 1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("t4_valid_drop", valid_out, 0);
    check("t4_ovr_sticky", overrun, 1);

    // restart mid-frame, then back-to-back
    step(1'b0, 1'b1, 1'b1, 1'($urandom), 1'b0);
    repeat (2)
      step(1'b0, 1'b0, 1'b1, 1'($urandom), 1'b0);
    check("t5_busy", busy, 1);
    push_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
    check("t5_ff", data_out, 8'hFF);
    push_frame(8'h01, 1'b0, 1'b1, 1'b0, 1'b0);
    check("t5_01", data_out, 8'h01);
    check("t5_valid", valid_out, 1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // reset mid-frame
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    repeat (4)
      step(1'b0, 1'b0, 1'b1, 1'($urandom), 1'b0);
    step(1'b1, 1'($urandom), 1'($urandom),
         1'($urandom), 1'($urandom));
    check("t6_rst_data", data_out, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_ovr", overrun, 0);
    push_frame(8'hC3, 1'b0, 1'b0, 1'b1, 1'b0);
    check("t6_data", data_out, 8'hC3);
    check("t6_perr", parity_err, PAR);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("t6_perr_clr", parity_err, 0);

    // random traffic
    repeat (3000)
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 7) == 0,
           $urandom_range(0, 3) != 0,
           1'($urandom),
           1'($urandom));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
